// File: rtl/odd_parity_rx_pkg.sv
// Shared definitions for the 8-bit odd-parity serial link (generator and receiver).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package odd_parity_pkg;

    localparam int ODD_PARITY_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Parity bit the generator appends: makes data plus parity hold an odd number of ones.
    function automatic logic odd_parity_bit(input logic [ODD_PARITY_DATA_W-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/odd_parity_rx_if.sv
// Bundle of serial-input and byte-output signals of odd_parity_rx.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the byte side; serial side has none.
// Optional: ODD_PARITY_RX_ERR_CNT_EN adds the err_count signal.
// Modports: master = line sampler + byte consumer, slave = the receiver.
interface odd_parity_rx_if #(
    parameter int DATA_W = 8
);
    logic              sin;
    logic              sin_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_parity_err;
    logic              out_frame_err;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              busy;
`ifdef ODD_PARITY_RX_ERR_CNT_EN
    logic [7:0]        err_count;
`endif

    modport master (
        output sin,
        output sin_valid,
        output out_ready,
        input  out_data,
        input  out_parity_err,
        input  out_frame_err,
        input  out_valid,
        input  overrun,
        input  busy
`ifdef ODD_PARITY_RX_ERR_CNT_EN
        ,
        input  err_count
`endif
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  out_ready,
        output out_data,
        output out_parity_err,
        output out_frame_err,
        output out_valid,
        output overrun,
        output busy
`ifdef ODD_PARITY_RX_ERR_CNT_EN
        ,
        output err_count
`endif
    );

endinterface

// File: rtl/odd_parity_out_reg.sv
// Single-entry valid/ready holding register for received frames, with overrun detection.
// Latency: a load appears on the outputs the cycle after load_vld.
// Backpressure: a load while a frame is held and out_rdy=0 is dropped and pulses overrun.
// Ports: load_* from the deserializer (one-cycle strobe), out_* to the consumer, overrun pulse.
module odd_parity_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_vld,
    input  logic [DATA_W-1:0] load_dat,
    input  logic              load_perr,
    input  logic              load_ferr,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              out_vld,
    output logic              overrun
);

    logic [DATA_W-1:0] dat_q, dat_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              vld_q, vld_d;
    logic              ovr_q, ovr_d;

    always_comb begin
        dat_d  = dat_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        vld_d  = vld_q;
        ovr_d  = 1'b0;

        if (vld_q && out_rdy) begin
            vld_d = 1'b0;
        end

        if (load_vld) begin
            // Slot is free if empty or being drained this very cycle.
            if (!vld_q || out_rdy) begin
                vld_d  = 1'b1;
                dat_d  = load_dat;
                perr_d = load_perr;
                ferr_d = load_ferr;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            vld_q  <= vld_d;
            ovr_q  <= ovr_d;
        end
    end

    assign out_dat  = dat_q;
    assign out_perr = perr_q;
    assign out_ferr = ferr_q;
    assign out_vld  = vld_q;
    assign overrun  = ovr_q;

endmodule

// File: rtl/odd_parity_rx.sv
// Odd-parity serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Latency: out_valid visible the cycle after the stop-bit strobe.
// Backpressure: one held frame; a new frame arriving while held and not ready is dropped (overrun).
// Ports: clk, rst_n (async active-low), bus (odd_parity_rx_if.slave).
// Optional: ODD_PARITY_RX_ERR_CNT_EN adds a saturating 8-bit error counter on bus.err_count.
module odd_parity_rx
    import odd_parity_pkg::*;
#(
    parameter int DATA_W = ODD_PARITY_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    odd_parity_rx_if.slave bus
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              busy_q, busy_d;

    logic              frame_done;
    logic              frame_perr;
    logic              frame_ferr;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_done = 1'b0;

        if (bus.sin_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.sin) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {bus.sin, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    par_d   = bus.sin;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    // A low stop bit is a framing error, never a new start bit.
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign frame_perr = (par_q != odd_parity_bit(shift_q));
    assign frame_ferr = ~bus.sin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy = busy_q;

    logic [DATA_W-1:0] o_dat;
    logic              o_perr;
    logic              o_ferr;
    logic              o_vld;
    logic              o_ovr;

    odd_parity_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_vld  (frame_done),
        .load_dat  (shift_q),
        .load_perr (frame_perr),
        .load_ferr (frame_ferr),
        .out_rdy   (bus.out_ready),
        .out_dat   (o_dat),
        .out_perr  (o_perr),
        .out_ferr  (o_ferr),
        .out_vld   (o_vld),
        .overrun   (o_ovr)
    );

    assign bus.out_data       = o_dat;
    assign bus.out_parity_err = o_perr;
    assign bus.out_frame_err  = o_ferr;
    assign bus.out_valid      = o_vld;
    assign bus.overrun        = o_ovr;

`ifdef ODD_PARITY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts every completed bad frame, stored or dropped; sticks at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_done && (frame_perr || frame_ferr) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_odd_parity_rx.sv
module tb_odd_parity_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    odd_parity_rx_if #(.DATA_W(8)) bus ();

    odd_parity_rx #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    int   err_total = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random with a guaranteed accept every 4 cycles
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Consumer: changes out_ready just after the rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0: bus.out_ready = 1'b0;
            1: bus.out_ready = 1'b1;
            default: bus.out_ready = (cyc % 4 == 0) ? 1'b1 : 1'($urandom);
        endcase
    end

    // Monitor: pops the scoreboard on every accepted frame, checks held data stays stable.
    logic       prev_hold = 1'b0;
    logic [9:0] prev_word = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.overrun) ovr_seen++;
            if (prev_hold) begin
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_stable", {22'd0, bus.out_data, bus.out_parity_err, bus.out_frame_err},
                    {22'd0, prev_word});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("frame", {22'd0, bus.out_data, bus.out_parity_err, bus.out_frame_err},
                        {22'd0, e.d, e.pe, e.fe});
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_word = {bus.out_data, bus.out_parity_err, bus.out_frame_err};
        end
    end

    task automatic send_bit(input logic b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            bus.sin_valid = 1'b0;
            bus.sin = 1'($urandom);
        end
        @(negedge clk);
        bus.sin = b;
        bus.sin_valid = 1'b1;
    endtask

    // Expected result from the frame rules: correct iff data plus parity has an odd count of ones.
    task automatic expect_frame(input logic [7:0] d, input logic p, input logic stop, input bit keep);
        exp_t e;
        e.d  = d;
        e.pe = ($countones({d, p}) % 2) == 0;
        e.fe = !stop;
        if (keep) sb_q.push_back(e);
        if ((e.pe || e.fe) && err_total < 255) err_total++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int gmax, input bit keep);
        expect_frame(d, p, stop, keep);
        send_bit(1'b0, gmax);
        for (int i = 0; i < 8; i++) send_bit(d[i], gmax);
        send_bit(p, gmax);
        send_bit(stop, gmax);
        @(negedge clk);
        bus.sin_valid = 1'b0;
        bus.sin = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        chk(name, sb_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_data"}, {24'd0, bus.out_data}, 32'd0);
        chk({name, "_perr"}, {31'd0, bus.out_parity_err}, 32'd0);
        chk({name, "_ferr"}, {31'd0, bus.out_frame_err}, 32'd0);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
`ifdef ODD_PARITY_RX_ERR_CNT_EN
        chk({name, "_errcnt"}, {24'd0, bus.err_count}, 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] d;
        int ovr0;
        a5 = 8'hA5;
        rst_n = 1'b0;
        bus.sin = 1'b1;
        bus.sin_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back 0xA5 with latency and busy window checks.
        ready_mode = 1;
        expect_frame(a5, 1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 0);
        chk("busy_before_start", {31'd0, bus.busy}, 32'd0);
        send_bit(a5[0], 0);
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i < 8; i++) send_bit(a5[i], 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("busy_stop_cycle", {31'd0, bus.busy}, 32'd1);
        chk("valid_before_stop", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.sin_valid = 1'b0;
        chk("valid_after_stop", {31'd0, bus.out_valid}, 32'd1);
        chk("busy_after_stop", {31'd0, bus.busy}, 32'd0);
        chk("a5_data", {24'd0, bus.out_data}, 32'hA5);
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);

        // Parity corner cases.
        send_frame(8'h00, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'h01, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1, 0, 1'b1);
        wait_drain("drain_parity");

        // Framing error followed immediately by a clean frame.
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b1);
        wait_drain("drain_framing");

        // Overrun: second frame dropped, first held unchanged.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        ovr0 = ovr_seen;
        send_frame(8'h11, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0);
        ovr_exp++;
        repeat (2) @(negedge clk);
        chk("ovr_held_data", {24'd0, bus.out_data}, 32'h11);
        chk("ovr_held_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ovr_pulses", ovr_seen - ovr0, 32'd1);
        ready_mode = 1;
        repeat (3) @(negedge clk);
        chk("ovr_consumed_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_drain("drain_overrun");

        // Gaps inside a frame must not change the result.
        send_frame(8'h5A, 1'b1, 1'b1, 3, 1'b1);
        wait_drain("drain_gaps");

        // Reset after four data bits discards the partial frame.
        d = 8'h5A;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1);
        @(negedge clk);
        bus.sin_valid = 1'b0;
        chk("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        err_total = 0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h77, 1'b1, 1'b1, 0, 1'b1);
        wait_drain("drain_after_reset");

        // Random frames, gaps, idle strobes and consumer stalls.
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = int'($urandom_range(2, 0));
            for (int k = 0; k < idle; k++) send_bit(1'b1, 1);
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(9, 0) != 0), 2, 1'b1);
        end
        wait_drain("drain_random");

`ifdef ODD_PARITY_RX_ERR_CNT_EN
        chk("errcnt_before_sat", {24'd0, bus.err_count}, err_total);
        ready_mode = 1;
        for (int n = 0; n < 260; n++) begin
            d = 8'($urandom);
            send_frame(d, ~(~(^d)), 1'b1, 0, 1'b1);
        end
        wait_drain("drain_errcnt");
        chk("errcnt_saturated", {24'd0, bus.err_count}, 32'd255);
`endif

        chk("overrun_total", ovr_seen, ovr_exp);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/odd_parity_rx.md
# odd_parity_rx

Serial frame receiver that is the check end of the team's 8-bit odd-parity link. It deserializes a strobed, LSB-first frame (start, 8 data, odd-parity, stop), verifies odd parity and stop-bit framing, and presents each byte with error flags through a valid/ready output register. It sits between the line sampler, which supplies one strobe per bit time, and the byte consumer.

## Interface
- `DATA_W`, default 8: data bits per frame. Only 8 is verified.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset. Release is synchronous to `clk` upstream.
- `sin` input 1: serial line. Idle level is 1.
- `sin_valid` input 1: sample strobe. `sin` is consumed only on cycles where this is 1.
- `out_data` output DATA_W: received byte.
- `out_parity_err` output 1: parity check failed for `out_data`.
- `out_frame_err` output 1: stop bit was 0 for `out_data`.
- `out_valid` output 1: output register holds an unconsumed frame.
- `out_ready` input 1: consumer accepts the frame when `out_valid` is also 1.
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: FSM is not in IDLE.
- `err_count` output 8: present only with `ODD_PARITY_RX_ERR_CNT_EN`.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on `sin_valid`=1 cycles; with `sin_valid`=0 all FSM state holds.
- IDLE: if `sin`=0, go to DATA and clear the bit index. If `sin`=1, stay in IDLE.
- DATA: shift `sin` in LSB first (bit index 0 to DATA_W-1). After bit DATA_W-1, go to PARITY.
- PARITY: capture `sin` as parity bit p, then go to STOP.
- STOP: compute `parity_err` = ~(^{data, p}). The frame is correct when data plus p contains an odd number of ones. For example, 0x00 requires p=1 and 0x01 requires p=0. `frame_err` = ~`sin`. Attempt to load the output register, then go to IDLE.
- A frame with a frame error still returns to IDLE. A stop bit of 0 is not treated as a new start bit.
- Output load rule at STOP completion:
  - If `out_valid`=0, load the frame.
  - If `out_valid`=1 and `out_ready`=1 in the same cycle, the old frame is consumed and the new one is loaded. `out_valid` stays 1.
  - If `out_valid`=1 and `out_ready`=0, drop the new frame, pulse `overrun`, and keep the held frame unchanged.
- `out_valid` clears on the cycle after `out_valid` && `out_ready` when no new load occurs.
- Output data and flags are stable while `out_valid`=1.
- Reset mid-frame: the partial frame is discarded and the FSM returns to IDLE. No output is produced.

## Timing
- Reset values: `out_data`=0, `out_parity_err`=0, `out_frame_err`=0, `out_valid`=0, `overrun`=0, `busy`=0, `err_count`=0. The FSM resets to IDLE and the shift register to 0.
- Latency: `out_valid` rises on the clock edge that samples the stop bit, so it is visible the cycle after that strobe.
- A minimum frame of 11 consecutive strobes gives `out_valid` 11 cycles after the start strobe.
- `busy` is high from the cycle after the start-bit strobe through the cycle of the stop-bit strobe.
- `overrun` is registered and high for exactly one cycle.
- There is no combinational path from `sin` or `out_ready` to any output.

## Configuration
- `ODD_PARITY_RX_ERR_CNT_EN` defined:
  - Adds the `err_count` port, an 8-bit counter.
  - Increments once per completed frame with `parity_err` | `frame_err`, whether or not the frame is stored.
  - Saturates at 255. Cleared only by reset.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `odd_parity_pkg`:
  - FSM state enum `rx_state_t`.
  - `ODD_PARITY_DATA_W` = 8.
  - Function `odd_parity_bit(data)` returning the generator's parity bit (~^data), so the check and the generator share one definition.
- Natural sub-module: `odd_parity_out_reg`, the valid/ready holding register with overrun detection.
- The FSM and shift register stay in the top module.

## Test plan
- Send frame 0xA5 with p=1 and stop=1, `out_ready` held 1 → `out_data`=0xA5, `parity_err`=0, `frame_err`=0, `out_valid` pulses for 1 cycle.
- Send 0x00 with p=0 → `parity_err`=1. Send 0x01 with p=1 → `parity_err`=1. Send 0x00 with p=1 → no error.
- Send 0x3C with correct p=1 and stop=0 → `frame_err`=1, `parity_err`=0. The next start bit is decoded normally.
- Hold `out_ready`=0 and send 0x11 then 0x22 → `out_data` stays 0x11, `overrun` pulses once. Then raise `out_ready` → 0x11 is consumed and `out_valid` goes to 0.
- Insert random `sin_valid`=0 gaps inside frame 0x5A → result is identical to the back-to-back case. Assert `rst_n`=0 after 4 data bits → all outputs return to reset values and `busy`=0. The next full frame 0x77 is received correctly.
- With `ODD_PARITY_RX_ERR_CNT_EN`, send 260 parity-error frames → `err_count` saturates at 255.
